// File: rtl/tts_pkg.sv
// Shared definitions for the truth-table sweeper: FSM encoding and default table width.
package tts_pkg;

  localparam int N_IN_DEF = 4;
  localparam int TT_W     = 2 ** N_IN_DEF;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_DRIVE  = 2'd1;
  localparam state_t S_SAMPLE = 2'd2;
  localparam state_t S_DONE   = 2'd3;

endpackage

// File: rtl/tts_if.sv
// Bundle between the sweeper and its controller/function under test.
// Handshake: start is a level that the sweeper acts on only in IDLE; done is a
// one-cycle pulse, and tt_out/match/err_cnt are valid from done until the next
// accepted start. There is no ready signal; a start outside IDLE is dropped.
interface tts_if
  import tts_pkg::*;
#(
  parameter int N_IN = 4
);
  localparam int TW = 2 ** N_IN;

  logic            start;
  logic [TW-1:0]   expect_tt;
  logic            f;
  logic [N_IN-1:0] vec;
  logic            busy;
  logic            done;
  logic [TW-1:0]   tt_out;
  logic            match;
  logic [N_IN:0]   err_cnt;
  state_t          dbg_state;

  modport master (
    output start, expect_tt, f,
    input  vec, busy, done, tt_out, match, err_cnt, dbg_state
  );

  modport slave (
    input  start, expect_tt, f,
    output vec, busy, done, tt_out, match, err_cnt, dbg_state
  );
endinterface

// File: rtl/tts_settle_cnt.sv
// Loadable down-counter timing how long each vector is held before sampling.
module tts_settle_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);
  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over decrement; stop at zero so tc stays asserted.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                    cnt_d = load_val_i;
    else if (en_i && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == '0);
endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all input combinations of a combinational function, captures its
// truth table and compares it against an expected table latched at start.
module truth_table_sweeper
  import tts_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 2
) (
  input logic  clk,
  input logic  rst_n,
  tts_if.slave bus
);
  localparam int            TW        = 2 ** N_IN;
  localparam logic [N_IN:0] LAST_IDX  = (N_IN + 1)'(TW - 1);
  localparam logic [3:0]    SETTLE_LD = 4'(SETTLE - 1);

  state_t          state_q, state_d;
  logic [N_IN:0]   idx_q, idx_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [TW-1:0]   tt_q, tt_d;
  logic            match_q, match_d;
  logic [N_IN:0]   err_q, err_d;
  logic [TW-1:0]   exp_q, exp_d;
  logic            settle_load;
  logic            settle_tc;
  logic            miss;

  // Times the DRIVE phase: loaded with SETTLE-1 on every entry into DRIVE.
  tts_settle_cnt #(.W(4)) u_settle (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (settle_load),
    .load_val_i (SETTLE_LD),
    .en_i       (state_q == S_DRIVE),
    .tc_o       (settle_tc)
  );

  // Sweep FSM with index, capture and error-count next-state logic.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    vec_d       = vec_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tt_d        = tt_q;
    match_d     = match_q;
    err_d       = err_q;
    exp_d       = exp_q;
    settle_load = 1'b0;
    miss        = bus.f ^ exp_q[idx_q[N_IN-1:0]];
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          exp_d       = bus.expect_tt;
          tt_d        = '0;
          err_d       = '0;
          match_d     = 1'b0;
          idx_d       = '0;
          vec_d       = '0;
          busy_d      = 1'b1;
          settle_load = 1'b1;
          state_d     = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (settle_tc) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        tt_d[idx_q[N_IN-1:0]] = bus.f;
        err_d = err_q + {{N_IN{1'b0}}, miss};
        if (idx_q == LAST_IDX) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          match_d = (err_d == '0);
          state_d = S_DONE;
        end else begin
          idx_d       = idx_q + 1'b1;
          vec_d       = idx_d[N_IN-1:0];
          settle_load = 1'b1;
          state_d     = S_DRIVE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any sweep in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tt_q    <= '0;
      match_q <= 1'b0;
      err_q   <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tt_q    <= tt_d;
      match_q <= match_d;
      err_q   <= err_d;
      exp_q   <= exp_d;
    end
  end

  assign bus.vec       = vec_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.tt_out    = tt_q;
  assign bus.match     = match_q;
  assign bus.err_cnt   = err_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper with a selectable 4-input function.
module tb_truth_table_sweeper;
  import tts_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [1:0] fsel;
  int         n_checks;
  int         n_fail;
  int         dcyc;
  int         ndone;
  logic       seen;

  tts_if #(.N_IN(4)) bus ();

  truth_table_sweeper #(.N_IN(4), .SETTLE(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Function under test: 0 = x&y&w&z, 1 = x^y^w^z, other = constant 0.
  assign bus.f = (fsel == 2'd0) ? (&bus.vec) :
                 (fsel == 2'd1) ? (^bus.vec) : 1'b0;

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts a sweep and waits (bounded) for done; returns the cycle done appeared,
  // counting the start cycle as 0. Optionally flips expect_tt mid-sweep.
  task automatic run_sweep(input logic [1:0] fs, input logic [15:0] exp_tt,
                           input int chg_at, output int done_cyc);
    int cyc;
    @(negedge clk);
    fsel          = fs;
    bus.expect_tt = exp_tt;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    while (!bus.done && cyc < 200) begin
      if (cyc == chg_at) bus.expect_tt = ~exp_tt;
      @(negedge clk);
      cyc++;
    end
    if (!bus.done) chk("done_timeout", 32'd0, 32'd1);
    done_cyc = cyc;
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    fsel          = 2'd0;
    bus.start     = 1'b0;
    bus.expect_tt = 16'h0000;
    rst_n         = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values.
    chk("rst_busy",    {31'd0, bus.busy},  32'd0);
    chk("rst_done",    {31'd0, bus.done},  32'd0);
    chk("rst_vec",     {28'd0, bus.vec},   32'd0);
    chk("rst_tt",      {16'd0, bus.tt_out}, 32'd0);
    chk("rst_match",   {31'd0, bus.match}, 32'd0);
    chk("rst_err",     {27'd0, bus.err_cnt}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_state",   {30'd0, bus.dbg_state}, {30'd0, S_IDLE});

    // 1. Reset mid-sweep at vec==5.
    fsel          = 2'd0;
    bus.expect_tt = 16'h8000;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 100 && bus.vec != 4'h5; i++) @(negedge clk);
    chk("mid_vec_reached", {28'd0, bus.vec}, 32'd5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_vec",  {28'd0, bus.vec},  32'd0);
    chk("mid_rst_tt",   {16'd0, bus.tt_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen = 1'b1;
    end
    chk("no_done_after_rst", {31'd0, seen}, 32'd0);

    // 2. AND function.
    run_sweep(2'd0, 16'h8000, 0, dcyc);
    chk("and_latency", dcyc, 32'd49);
    chk("and_tt",    {16'd0, bus.tt_out}, 32'h8000);
    chk("and_match", {31'd0, bus.match}, 32'd1);
    chk("and_err",   {27'd0, bus.err_cnt}, 32'd0);
    chk("and_busy_in_done", {31'd0, bus.busy}, 32'd0);
    chk("and_vec_hold", {28'd0, bus.vec}, 32'hF);
    @(negedge clk);
    chk("and_done_pulse", {31'd0, bus.done}, 32'd0);
    chk("and_match_hold", {31'd0, bus.match}, 32'd1);

    // 3. Parity, with expect_tt disturbed mid-sweep (must be ignored).
    run_sweep(2'd1, 16'h6996, 10, dcyc);
    chk("xor_latency", dcyc, 32'd49);
    chk("xor_tt",    {16'd0, bus.tt_out}, 32'h6996);
    chk("xor_match", {31'd0, bus.match}, 32'd1);
    chk("xor_err",   {27'd0, bus.err_cnt}, 32'd0);
    run_sweep(2'd1, 16'h6997, 0, dcyc);
    chk("xor1_match", {31'd0, bus.match}, 32'd0);
    chk("xor1_err",   {27'd0, bus.err_cnt}, 32'd1);

    // 4. Constant zero against all ones: err_cnt reaches 16.
    run_sweep(2'd2, 16'hFFFF, 0, dcyc);
    chk("zero_tt",    {16'd0, bus.tt_out}, 32'h0);
    chk("zero_err",   {27'd0, bus.err_cnt}, 32'h10);
    chk("zero_match", {31'd0, bus.match}, 32'd0);

    // 5. start while busy is ignored; start held high restarts after DONE.
    @(negedge clk);
    fsel          = 2'd1;
    bus.expect_tt = 16'h6996;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    ndone = 0;
    dcyc  = 0;
    for (int c = 1; c <= 51; c++) begin
      if (bus.done) begin
        ndone++;
        dcyc = c;
      end
      if (c == 50) chk("restart_idle_c50", {31'd0, bus.busy}, 32'd0);
      if (c == 51) chk("restart_busy_c51", {31'd0, bus.busy}, 32'd1);
      if (c == 20) bus.start = 1'b1;
      if (c == 21) bus.start = 1'b0;
      if (c == 45) bus.start = 1'b1;
      @(negedge clk);
    end
    chk("ignored_start_ndone", ndone, 32'd1);
    chk("ignored_start_dcyc",  dcyc,  32'd49);
    bus.start = 1'b0;
    dcyc = 52;
    while (!bus.done && dcyc < 200) begin
      @(negedge clk);
      dcyc++;
    end
    chk("second_sweep_done_cyc", dcyc, 32'd99);
    chk("second_sweep_tt", {16'd0, bus.tt_out}, 32'h6996);
    chk("second_sweep_match", {31'd0, bus.match}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
